udp_wide_send: RTL and testbench

- Parametrised successor to the fixed 128-bit UDP payload sender.
- Takes DATA_W-bit words from the DDR3 read path and serialises them MSB-byte-first into the UDP/MAC byte interface.
- Optionally prepends a 2-byte MJPEG header {last_frame_flag, frame_rank[14:0]}.
- Sits between the DDR3 frame reader and udp_send. One instance handles one UDP packet per i_en start.

---
 rtl/udp_wide_send.sv | 231 +++++++++++++++++++++++
 tb/tb_udp_wide_send.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_wide_send.sv
// udp_wide_send: serialises DATA_W-bit words from the DDR3 read path MSB-byte-first
// into the udp_send byte interface, optionally preceded by a 2-byte MJPEG header
// {last_frame_flag, frame_rank[14:0]}. One packet per i_en start.
module udp_wide_send #(
   parameter int DATA_W    = 128,
   parameter int HDR_BYTES = 2,
   parameter int LEN_W     = 16
) (
   input  logic              i_udp_clk50m,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_last_frame_flag,
   input  logic [14:0]       i_mjpeg_frame_rank,
   input  logic [LEN_W-1:0]  i_payload_len,
   input  logic [15:0]       i_ipv4_sign,
   output logic              o_word_req,
   input  logic              i_word_vld,
   input  logic [DATA_W-1:0] i_word_data,
   output logic              o_udp_tx_en,
   output logic [7:0]        o_udp_data,
   output logic [LEN_W-1:0]  o_udp_data_len,
   output logic [15:0]       o_ipv4_sign,
   input  logic              i_udp_head_down,
   input  logic              i_udp_isLoadData,
   input  logic              i_udp_busy,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic              o_underrun
);

   localparam int               BPW     = DATA_W / 8;
   localparam int               CNT_W   = $clog2(BPW + 1);
   localparam logic [CNT_W-1:0] BPW_C   = CNT_W'(BPW);
   localparam logic [LEN_W-1:0] HDR_C   = LEN_W'(HDR_BYTES);
   localparam logic [LEN_W:0]   BPW_REQ = (LEN_W+1)'(BPW);

   typedef enum logic [2:0] {IDLE, WAIT_HEAD, HDR, DATA, DRAIN, FINISH} state_t;

   state_t            state;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  rem_q;
   logic [LEN_W:0]    req_bytes_q;   // bytes covered by words requested so far
   logic [15:0]       hdr_q;
   logic              hdr_idx_q;
   logic              head_down_d;

   logic [DATA_W-1:0] sh_q;          // current word, next byte on top
   logic [CNT_W-1:0]  sh_cnt_q;      // unsent bytes left in sh_q
   logic [DATA_W-1:0] pf_q;          // prefetched word
   logic              pf_vld_q;

   logic              start;
   logic              dp_active;
   logic              consume;
   logic [LEN_W-1:0]  total_len;
   logic [DATA_W-1:0] sh_nxt;
   logic [CNT_W-1:0]  sh_cnt_nxt;
   logic [DATA_W-1:0] pf_nxt;
   logic              pf_vld_nxt;
   logic              loaded;
   logic              bypass;
   logic              underrun_hit;
   logic [7:0]        dp_byte;

   assign start     = (state == IDLE) && i_en;
   assign dp_active = (state == WAIT_HEAD) || (state == HDR) || (state == DATA);
   assign consume   = (state == DATA) && i_udp_isLoadData;
   assign total_len = i_payload_len + HDR_C;

   // Next word-path state: consume a byte, refill from prefetch (or straight from the
   // bus when both are empty so a late word is usable one cycle after i_word_vld).
   always_comb begin
      sh_nxt       = sh_q;
      sh_cnt_nxt   = sh_cnt_q;
      pf_nxt       = pf_q;
      pf_vld_nxt   = pf_vld_q;
      loaded       = 1'b0;
      bypass       = 1'b0;
      underrun_hit = 1'b0;
      if (dp_active) begin
         if (consume) begin
            if (sh_cnt_q != '0) begin
               sh_nxt     = sh_q << 8;
               sh_cnt_nxt = sh_cnt_q - CNT_W'(1);
            end else begin
               underrun_hit = 1'b1;
            end
         end
         if (sh_cnt_nxt == '0) begin
            if (pf_vld_q) begin
               sh_nxt     = pf_q;
               sh_cnt_nxt = BPW_C;
               pf_vld_nxt = 1'b0;
               loaded     = 1'b1;
            end else if (i_word_vld) begin
               sh_nxt     = i_word_data;
               sh_cnt_nxt = BPW_C;
               loaded     = 1'b1;
               bypass     = 1'b1;
            end
         end
         if (i_word_vld && !bypass && !pf_vld_nxt) begin
            pf_nxt     = i_word_data;
            pf_vld_nxt = 1'b1;
         end
      end
      dp_byte = (sh_cnt_nxt != '0) ? sh_nxt[DATA_W-1 -: 8] : 8'h00;
   end

   // Word path registers and word-request generation.
   always_ff @(posedge i_udp_clk50m) begin
      sh_q <= sh_nxt;
      pf_q <= pf_nxt;
      if (!i_rst_n) begin
         sh_cnt_q    <= '0;
         pf_vld_q    <= 1'b0;
         o_word_req  <= 1'b0;
         req_bytes_q <= '0;
      end else if (start) begin
         sh_cnt_q    <= '0;
         pf_vld_q    <= 1'b0;
         o_word_req  <= (i_payload_len != '0);
         req_bytes_q <= (i_payload_len != '0) ? BPW_REQ : '0;
      end else begin
         sh_cnt_q <= sh_cnt_nxt;
         pf_vld_q <= pf_vld_nxt;
         if (loaded && (req_bytes_q < {1'b0, len_q})) begin
            o_word_req  <= 1'b1;
            req_bytes_q <= req_bytes_q + BPW_REQ;
         end else begin
            o_word_req  <= 1'b0;
         end
      end
   end

   // Packet sequencer with registered outputs; o_udp_data always shows the byte
   // udp_send will take on its next i_udp_isLoadData.
   always_ff @(posedge i_udp_clk50m) begin
      if (!i_rst_n) begin
         state          <= IDLE;
         o_udp_tx_en    <= 1'b0;
         o_udp_data     <= 8'h00;
         o_udp_data_len <= '0;
         o_ipv4_sign    <= 16'h0000;
         o_busy         <= 1'b0;
         o_frame_done   <= 1'b0;
         o_underrun     <= 1'b0;
         len_q          <= '0;
         rem_q          <= '0;
         hdr_q          <= 16'h0000;
         hdr_idx_q      <= 1'b0;
         head_down_d    <= 1'b0;
      end else begin
         head_down_d  <= i_udp_head_down;
         o_frame_done <= 1'b0;
         if (underrun_hit) o_underrun <= 1'b1;
         case (state)
            IDLE: begin
               if (i_en) begin
                  len_q          <= i_payload_len;
                  rem_q          <= i_payload_len;
                  hdr_q          <= {i_last_frame_flag, i_mjpeg_frame_rank};
                  hdr_idx_q      <= 1'b0;
                  o_ipv4_sign    <= i_ipv4_sign;
                  o_udp_data_len <= total_len;
                  o_underrun     <= 1'b0;
                  o_busy         <= 1'b1;
                  if (total_len == '0) begin
                     state       <= FINISH;
                     o_udp_tx_en <= 1'b0;
                  end else begin
                     state       <= WAIT_HEAD;
                     o_udp_tx_en <= 1'b1;
                  end
               end
            end
            WAIT_HEAD: begin
               if (i_udp_head_down && !head_down_d) begin
                  if (HDR_BYTES == 2) begin
                     state      <= HDR;
                     o_udp_data <= hdr_q[15:8];
                  end else begin
                     state      <= DATA;
                     o_udp_data <= dp_byte;
                  end
               end
            end
            HDR: begin
               if (i_udp_isLoadData) begin
                  if (!hdr_idx_q) begin
                     hdr_idx_q  <= 1'b1;
                     o_udp_data <= hdr_q[7:0];
                  end else if (len_q != '0) begin
                     state      <= DATA;
                     o_udp_data <= dp_byte;
                  end else begin
                     state       <= DRAIN;
                     o_udp_tx_en <= 1'b0;
                     o_udp_data  <= 8'h00;
                  end
               end
            end
            DATA: begin
               o_udp_data <= dp_byte;
               if (i_udp_isLoadData) begin
                  rem_q <= rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     state       <= DRAIN;
                     o_udp_tx_en <= 1'b0;
                     o_udp_data  <= 8'h00;
                  end
               end
            end
            DRAIN: begin
               if (!i_udp_busy) state <= FINISH;
            end
            FINISH: begin
               state        <= IDLE;
               o_busy       <= 1'b0;
               o_frame_done <= 1'b1;
            end
            default: begin
               state       <= IDLE;
               o_busy      <= 1'b0;
               o_udp_tx_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_udp_wide_send.sv
// tb_udp_wide_send: directed bench for udp_wide_send with a udp_send / DDR word-source
// responder and a byte scoreboard. Instance A: 128-bit words with header; instance B:
// 64-bit words without header.
module tb_udp_wide_send;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en_a = 1'b0, en_b = 1'b0;
   logic         flag = 1'b0;
   logic [14:0]  rank = '0;
   logic [15:0]  len = '0;
   logic [15:0]  sign = '0;
   logic         word_vld = 1'b0;
   logic [127:0] word_a = '0;
   logic [63:0]  word_b = '0;
   logic         head_down = 1'b0;
   logic         load = 1'b0;
   logic         ubusy = 1'b0;

   logic         req_a, txen_a, busy_a, done_a, unr_a;
   logic [7:0]   data_a;
   logic [15:0]  dlen_a, sgn_a;
   logic         req_b, txen_b, busy_b, done_b, unr_b;
   logic [7:0]   data_b;
   logic [15:0]  dlen_b, sgn_b;

   always #10 clk = ~clk;

   udp_wide_send #(.DATA_W(128), .HDR_BYTES(2), .LEN_W(16)) u_a (
      .i_udp_clk50m(clk), .i_rst_n(rst_n), .i_en(en_a),
      .i_last_frame_flag(flag), .i_mjpeg_frame_rank(rank),
      .i_payload_len(len), .i_ipv4_sign(sign),
      .o_word_req(req_a), .i_word_vld(word_vld), .i_word_data(word_a),
      .o_udp_tx_en(txen_a), .o_udp_data(data_a), .o_udp_data_len(dlen_a),
      .o_ipv4_sign(sgn_a), .i_udp_head_down(head_down),
      .i_udp_isLoadData(load), .i_udp_busy(ubusy),
      .o_busy(busy_a), .o_frame_done(done_a), .o_underrun(unr_a));

   udp_wide_send #(.DATA_W(64), .HDR_BYTES(0), .LEN_W(16)) u_b (
      .i_udp_clk50m(clk), .i_rst_n(rst_n), .i_en(en_b),
      .i_last_frame_flag(flag), .i_mjpeg_frame_rank(rank),
      .i_payload_len(len), .i_ipv4_sign(sign),
      .o_word_req(req_b), .i_word_vld(word_vld), .i_word_data(word_b),
      .o_udp_tx_en(txen_b), .o_udp_data(data_b), .o_udp_data_len(dlen_b),
      .o_ipv4_sign(sgn_b), .i_udp_head_down(head_down),
      .i_udp_isLoadData(load), .i_udp_busy(ubusy),
      .o_busy(busy_b), .o_frame_done(done_b), .o_underrun(unr_b));

   int n_checks = 0;
   int n_errors = 0;
   int exp_q[$];
   int pend[$];

   int res_nreq, res_ndone, res_done_cyc, res_busylow;
   bit res_txen_seen, res_txen_last, res_txen_after, res_unr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] mk_word_a(input int k);
      logic [127:0] w;
      w = '0;
      for (int b = 0; b < 16; b++) w[127-8*b -: 8] = 8'((k*16 + b) & 255);
      return w;
   endfunction

   function automatic logic [63:0] mk_word_b(input int k);
      logic [63:0] w;
      w = '0;
      for (int b = 0; b < 8; b++) w[63-8*b -: 8] = 8'((k*8 + b) & 255);
      return w;
   endfunction

   // One packet on instance sel (0=A, 1=B). Word hold_idx is withheld until payload
   // strobe hold_at; rst_at>0 pulls reset instead of issuing that payload strobe.
   task automatic run_packet(input int sel, input int plen, input bit fl, input int rk,
                             input int sg, input int hold_idx, input int hold_at,
                             input int rst_at, input string nm);
      int   hdr, total, nstr, next_word, head_cyc, last_cyc, e;
      logic req_o, txen_o, done_o, unr_o;
      logic [7:0] data_o;
      logic [7:0] hb;
      hdr   = (sel == 0) ? 2 : 0;
      total = plen + hdr;
      exp_q.delete();
      pend.delete();
      if (hdr == 2) begin
         hb = {fl, rk[14:8]};
         exp_q.push_back(int'(hb));
         exp_q.push_back(rk & 255);
      end
      for (int i = 0; i < plen; i++) begin
         if (hold_idx >= 0 && i == hold_at - 1) exp_q.push_back(0);
         else if (hold_idx >= 0 && i >= hold_at) exp_q.push_back(-1);
         else exp_q.push_back(i & 255);
      end
      @(negedge clk);
      flag = fl; rank = rk[14:0]; len = plen[15:0]; sign = sg[15:0];
      if (sel == 0) en_a = 1'b1; else en_b = 1'b1;
      nstr = 0; next_word = 0; head_cyc = -1; last_cyc = -1;
      res_nreq = 0; res_ndone = 0; res_done_cyc = -1; res_busylow = -1;
      res_txen_seen = 0; res_txen_last = 0; res_txen_after = 1; res_unr = 0;
      for (int cyc = 1; cyc <= 600; cyc++) begin
         @(negedge clk);
         en_a = 1'b0; en_b = 1'b0; word_vld = 1'b0; load = 1'b0;
         req_o  = (sel == 0) ? req_a  : req_b;
         txen_o = (sel == 0) ? txen_a : txen_b;
         done_o = (sel == 0) ? done_a : done_b;
         unr_o  = (sel == 0) ? unr_a  : unr_b;
         data_o = (sel == 0) ? data_a : data_b;
         res_unr = unr_o;
         if (done_o) begin
            res_ndone++;
            if (res_done_cyc < 0) res_done_cyc = cyc;
         end
         if (txen_o) res_txen_seen = 1;
         if (req_o) begin
            res_nreq++;
            pend.push_back(next_word);
            next_word++;
         end
         if (last_cyc >= 0 && cyc == last_cyc + 1) res_txen_after = txen_o;
         if (last_cyc >= 0 && cyc == last_cyc + 3) begin
            ubusy = 1'b0; head_down = 1'b0; res_busylow = cyc;
         end
         if (head_cyc < 0 && txen_o && cyc >= 3) begin
            head_down = 1'b1; ubusy = 1'b1; head_cyc = cyc;
         end else if (head_cyc >= 0 && cyc > head_cyc && nstr < total) begin
            if (rst_at > 0 && nstr - hdr + 1 == rst_at) begin
               rst_n = 1'b0;
               break;
            end
            load = 1'b1;
            nstr++;
            e = exp_q.pop_front();
            if (e >= 0) chk($sformatf("%s byte%0d", nm, nstr), {24'h0, data_o}, e);
            if (nstr == total) begin
               last_cyc = cyc;
               res_txen_last = txen_o;
            end
         end
         if (pend.size() > 0) begin
            if (!(pend[0] == hold_idx && (nstr - hdr) < hold_at)) begin
               word_vld = 1'b1;
               word_a   = mk_word_a(pend[0]);
               word_b   = mk_word_b(pend[0]);
               void'(pend.pop_front());
            end
         end
         if (res_done_cyc >= 0 && cyc >= res_done_cyc + 2) break;
      end
   endtask

   initial begin
      int nd;
      // reset state
      repeat (3) @(negedge clk);
      chk("rst txen_a",  {31'h0, txen_a}, 0);
      chk("rst busy_a",  {31'h0, busy_a}, 0);
      chk("rst done_a",  {31'h0, done_a}, 0);
      chk("rst req_a",   {31'h0, req_a},  0);
      chk("rst data_a",  {24'h0, data_a}, 0);
      chk("rst dlen_a",  {16'h0, dlen_a}, 0);
      chk("rst unr_a",   {31'h0, unr_a},  0);
      chk("rst txen_b",  {31'h0, txen_b}, 0);
      chk("rst busy_b",  {31'h0, busy_b}, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // T1: 128-bit, header, len 32
      run_packet(0, 32, 1'b1, 15'h0005, 16'h1234, -1, 0, 0, "t1");
      chk("t1 dlen",      {16'h0, dlen_a}, 34);
      chk("t1 sign",      {16'h0, sgn_a}, 32'h1234);
      chk("t1 nreq",      res_nreq, 2);
      chk("t1 ndone",     res_ndone, 1);
      chk("t1 txen_last", {31'h0, res_txen_last}, 1);
      chk("t1 txen_fall", {31'h0, res_txen_after}, 0);
      chk("t1 underrun",  {31'h0, res_unr}, 0);
      chk("t1 done_cyc",  res_done_cyc, res_busylow + 2);

      // T2: 64-bit, no header, partial last word
      run_packet(1, 13, 1'b0, 15'h0007, 16'h55AA, -1, 0, 0, "t2");
      chk("t2 dlen",      {16'h0, dlen_b}, 13);
      chk("t2 sign",      {16'h0, sgn_b}, 32'h55AA);
      chk("t2 nreq",      res_nreq, 2);
      chk("t2 ndone",     res_ndone, 1);
      chk("t2 txen_last", {31'h0, res_txen_last}, 1);
      chk("t2 txen_fall", {31'h0, res_txen_after}, 0);

      // T3: header only
      run_packet(0, 0, 1'b0, 15'h1234, 16'h0001, -1, 0, 0, "t3");
      chk("t3 dlen",      {16'h0, dlen_a}, 2);
      chk("t3 nreq",      res_nreq, 0);
      chk("t3 ndone",     res_ndone, 1);
      chk("t3 txen_fall", {31'h0, res_txen_after}, 0);
      chk("t3 done_cyc",  res_done_cyc, res_busylow + 2);

      // T4: empty packet without header
      run_packet(1, 0, 1'b0, 0, 16'h0002, -1, 0, 0, "t4");
      chk("t4 txen_seen", {31'h0, res_txen_seen}, 0);
      chk("t4 nreq",      res_nreq, 0);
      chk("t4 ndone",     res_ndone, 1);
      chk("t4 done_cyc",  res_done_cyc, 2);
      chk("t4 dlen",      {16'h0, dlen_b}, 0);

      // T5: second word withheld until payload strobe 17
      run_packet(0, 32, 1'b0, 15'h0042, 16'h0BAD, 1, 17, 0, "t5");
      chk("t5 underrun",  {31'h0, res_unr}, 1);
      chk("t5 nreq",      res_nreq, 2);
      chk("t5 ndone",     res_ndone, 1);
      chk("t5 txen_last", {31'h0, res_txen_last}, 1);
      chk("t5 txen_fall", {31'h0, res_txen_after}, 0);

      // T6: reset during DATA, then a fresh packet
      run_packet(0, 32, 1'b1, 15'h0003, 16'h0077, -1, 0, 5, "t6a");
      @(negedge clk);
      chk("t6 rst txen", {31'h0, txen_a}, 0);
      chk("t6 rst busy", {31'h0, busy_a}, 0);
      chk("t6 rst done", {31'h0, done_a}, 0);
      chk("t6 rst data", {24'h0, data_a}, 0);
      rst_n = 1'b1; head_down = 1'b0; ubusy = 1'b0; load = 1'b0;
      nd = 0;
      repeat (5) begin
         @(negedge clk);
         if (done_a) nd++;
      end
      chk("t6 no done", nd, 0);
      run_packet(0, 32, 1'b0, 15'h7ABC, 16'hBEEF, -1, 0, 0, "t6b");
      chk("t6b dlen",      {16'h0, dlen_a}, 34);
      chk("t6b sign",      {16'h0, sgn_a}, 32'hBEEF);
      chk("t6b nreq",      res_nreq, 2);
      chk("t6b ndone",     res_ndone, 1);
      chk("t6b underrun",  {31'h0, res_unr}, 0);
      chk("t6b txen_fall", {31'h0, res_txen_after}, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
